// File: rtl/lcd_frame_writer_if.sv
// lcd_frame_writer bus: PPU pixel stream in, frame-buffer
// write port and status strobes out.
interface lcd_frame_writer_if;
    logic [1:0]  pixel_in;
    logic        pixel_valid_in;
    logic        hblank_in;
    logic        vblank_in;
    logic        wr_en_out;
    logic [15:0] wr_addr_out;
    logic [1:0]  wr_data_out;
    logic        front_bank_out;
    logic        frame_done_out;
    logic        line_err_out;
    logic        frame_err_out;
    logic        overflow_out;

    modport master (
        output pixel_in,
        output pixel_valid_in,
        output hblank_in,
        output vblank_in,
        input  wr_en_out,
        input  wr_addr_out,
        input  wr_data_out,
        input  front_bank_out,
        input  frame_done_out,
        input  line_err_out,
        input  frame_err_out,
        input  overflow_out
    );

    modport slave (
        input  pixel_in,
        input  pixel_valid_in,
        input  hblank_in,
        input  vblank_in,
        output wr_en_out,
        output wr_addr_out,
        output wr_data_out,
        output front_bank_out,
        output frame_done_out,
        output line_err_out,
        output frame_err_out,
        output overflow_out
    );
endinterface

// File: rtl/lcd_frame_writer.sv
// lcd_frame_writer: raster tracker that writes PPU shades into a
// double-buffered frame buffer and swaps banks at every VBlank.
module lcd_frame_writer #(
    parameter int H_PIXELS = 160,
    parameter int V_LINES  = 144
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    lcd_frame_writer_if.slave bus
);

    localparam logic [7:0]  LP_H   = 8'(H_PIXELS);
    localparam logic [7:0]  LP_V   = 8'(V_LINES);
    localparam logic [14:0] LP_HW  = 15'(H_PIXELS);

    typedef enum logic [1:0] {
        SYNC,
        ACTIVE,
        HBLANK,
        VBLANK
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_hb;
    logic        r_hb_prev;
    logic        r_vb;
    logic        r_vb_prev;

    logic [7:0]  r_x;
    logic [7:0]  r_y;
    logic [14:0] r_base;
    logic [7:0]  w_x_nxt;
    logic [7:0]  w_y_nxt;
    logic [14:0] w_base_nxt;
    logic [7:0]  w_y_inc;

    logic        r_wr_en;
    logic [15:0] r_wr_addr;
    logic [1:0]  r_wr_data;
    logic        r_front;
    logic        r_done;
    logic        r_line_err;
    logic        r_frame_err;
    logic        r_ovf;

    logic        w_wr_en;
    logic [15:0] w_wr_addr;
    logic        w_front_nxt;
    logic        w_done;
    logic        w_line_err;
    logic        w_frame_err;
    logic        w_ovf_nxt;

    logic        w_hb_rise;
    logic        w_hb_fall;
    logic        w_vb_rise;
    logic        w_vb_fall;
    logic        w_in_range;

    assign w_hb_rise  = r_hb & ~r_hb_prev;
    assign w_hb_fall  = ~r_hb & r_hb_prev;
    assign w_vb_rise  = r_vb & ~r_vb_prev;
    assign w_vb_fall  = ~r_vb & r_vb_prev;
    assign w_in_range = (r_x < LP_H) && (r_y < LP_V);
    assign w_y_inc    = (r_y == 8'hFF) ? r_y : r_y + 8'd1;
    assign w_wr_addr  = {~r_front, r_base + {7'd0, r_x}};

    // Blank levels captured, then delayed once more for edge detection;
    // prev starts high so a level already high at release is no edge.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_hb      <= 1'b1;
            r_hb_prev <= 1'b1;
            r_vb      <= 1'b1;
            r_vb_prev <= 1'b1;
        end else begin
            r_hb      <= bus.hblank_in;
            r_hb_prev <= r_hb;
            r_vb      <= bus.vblank_in;
            r_vb_prev <= r_vb;
        end
    end

    // Raster state, position counters and registered outputs.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state     <= SYNC;
            r_x         <= 8'd0;
            r_y         <= 8'd0;
            r_base      <= 15'd0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= 16'd0;
            r_wr_data   <= 2'd0;
            r_front     <= 1'b0;
            r_done      <= 1'b0;
            r_line_err  <= 1'b0;
            r_frame_err <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_x         <= w_x_nxt;
            r_y         <= w_y_nxt;
            r_base      <= w_base_nxt;
            r_wr_en     <= w_wr_en;
            if (w_wr_en) begin
                r_wr_addr <= w_wr_addr;
                r_wr_data <= bus.pixel_in;
            end
            r_front     <= w_front_nxt;
            r_done      <= w_done;
            r_line_err  <= w_line_err;
            r_frame_err <= w_frame_err;
            r_ovf       <= w_ovf_nxt;
        end
    end

    // Next-state: accept the coincident pixel before closing the line,
    // and close the line before judging the frame.
    always_comb begin
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_base_nxt  = r_base;
        w_wr_en     = 1'b0;
        w_front_nxt = r_front;
        w_done      = 1'b0;
        w_line_err  = 1'b0;
        w_frame_err = 1'b0;
        w_ovf_nxt   = r_ovf;
        unique case (r_state)
            SYNC: begin
                if (w_vb_fall) begin
                    w_state_nxt = ACTIVE;
                    w_x_nxt     = 8'd0;
                    w_y_nxt     = 8'd0;
                    w_base_nxt  = 15'd0;
                end
            end
            ACTIVE: begin
                if (bus.pixel_valid_in) begin
                    if (w_in_range) begin
                        w_wr_en = 1'b1;
                        w_x_nxt = r_x + 8'd1;
                    end else begin
                        w_ovf_nxt = 1'b1;
                    end
                end
                if (w_hb_rise) begin
                    w_line_err  = (w_x_nxt != LP_H);
                    w_y_nxt     = w_y_inc;
                    w_base_nxt  = r_base + LP_HW;
                    w_state_nxt = HBLANK;
                end
                if (w_vb_rise) begin
                    w_frame_err = (w_y_nxt != LP_V);
                    w_front_nxt = ~r_front;
                    w_done      = 1'b1;
                    w_state_nxt = VBLANK;
                end
            end
            HBLANK: begin
                if (bus.pixel_valid_in) begin
                    w_ovf_nxt = 1'b1;
                end
                if (w_hb_fall) begin
                    w_x_nxt     = 8'd0;
                    w_state_nxt = ACTIVE;
                end
                if (w_vb_rise) begin
                    w_frame_err = (r_y != LP_V);
                    w_front_nxt = ~r_front;
                    w_done      = 1'b1;
                    w_state_nxt = VBLANK;
                end
            end
            VBLANK: begin
                if (w_vb_fall) begin
                    w_state_nxt = ACTIVE;
                    w_x_nxt     = 8'd0;
                    w_y_nxt     = 8'd0;
                    w_base_nxt  = 15'd0;
                end
            end
        endcase
    end

    assign bus.wr_en_out      = r_wr_en;
    assign bus.wr_addr_out    = r_wr_addr;
    assign bus.wr_data_out    = r_wr_data;
    assign bus.front_bank_out = r_front;
    assign bus.frame_done_out = r_done;
    assign bus.line_err_out   = r_line_err;
    assign bus.frame_err_out  = r_frame_err;
    assign bus.overflow_out   = r_ovf;

endmodule

// File: tb/tb_lcd_frame_writer.sv
// Scoreboard bench for lcd_frame_writer: expected writes queued as
// pixels are driven, popped as the write port fires.
module tb_lcd_frame_writer;

    logic clk_in = 1'b0;
    logic rst_n_in;

    always #5 clk_in = ~clk_in;

    lcd_frame_writer_if bus();

    lcd_frame_writer #(
        .H_PIXELS(160),
        .V_LINES (144)
    ) dut (
        .clk_in  (clk_in),
        .rst_n_in(rst_n_in),
        .bus     (bus)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [17:0] exp_q[$];
    logic [17:0] e;

    int          ln;
    int          col;
    logic        bank;

    int          n_wr;
    int          c_le;
    int          c_fe;
    int          c_fd;
    logic [15:0] first_a;
    logic [15:0] last_a;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Write-port monitor and pulse counters.
    always @(negedge clk_in) begin
        if (bus.wr_en_out === 1'b1) begin
            n_wr++;
            if (n_wr == 1) first_a = bus.wr_addr_out;
            last_a = bus.wr_addr_out;
            if (exp_q.size() == 0) begin
                chk("spurious_wr", 32'(bus.wr_en_out), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("wr", 32'({bus.wr_addr_out, bus.wr_data_out}),
                    32'(e));
            end
        end
        if (bus.line_err_out === 1'b1)   c_le++;
        if (bus.frame_err_out === 1'b1)  c_fe++;
        if (bus.frame_done_out === 1'b1) c_fd++;
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic clr_cnt();
        n_wr = 0;
        c_le = 0;
        c_fe = 0;
        c_fd = 0;
    endtask

    task automatic px(input bit blank);
        logic [1:0] d;
        d = 2'($urandom);
        bus.pixel_in       = d;
        bus.pixel_valid_in = 1'b1;
        if (!blank && col < 160 && ln < 144) begin
            exp_q.push_back({bank, 15'(ln * 160 + col), d});
            col++;
        end
        step();
        bus.pixel_valid_in = 1'b0;
    endtask

    task automatic hb(input bit with_px);
        bus.hblank_in = 1'b1;
        repeat (3) step();
        if (with_px) px(1'b1);
        bus.hblank_in = 1'b0;
        repeat (3) step();
        ln++;
        col = 0;
    endtask

    task automatic frame_start();
        bus.vblank_in = 1'b0;
        repeat (3) step();
        ln  = 0;
        col = 0;
        clr_cnt();
    endtask

    task automatic frame_end();
        bus.vblank_in = 1'b1;
        repeat (4) step();
        bank = ~bank;
    endtask

    task automatic full_frame();
        frame_start();
        for (int l = 0; l < 144; l++) begin
            repeat (160) px(1'b0);
            hb(1'b0);
        end
        frame_end();
    endtask

    initial begin
        rst_n_in           = 1'b0;
        bus.pixel_in       = 2'd0;
        bus.pixel_valid_in = 1'b0;
        bus.hblank_in      = 1'b0;
        bus.vblank_in      = 1'b1;
        bank = 1'b1;
        ln   = 0;
        col  = 0;
        clr_cnt();
        repeat (3) step();
        chk("rst_wr_en", 32'(bus.wr_en_out), 32'd0);
        chk("rst_front", 32'(bus.front_bank_out), 32'd0);
        chk("rst_ovf", 32'(bus.overflow_out), 32'd0);
        chk("rst_addr", 32'(bus.wr_addr_out), 32'd0);
        rst_n_in = 1'b1;
        repeat (2) step();
        chk("rel_front", 32'(bus.front_bank_out), 32'd0);
        chk("rel_done", 32'(c_fd), 32'd0);

        // Frame A: full frame into bank 1.
        full_frame();
        chk("A_nwr", 32'(n_wr), 32'd23040);
        chk("A_first", 32'(first_a), 32'h8000);
        chk("A_last", 32'(last_a), 32'hD9FF);
        chk("A_done", 32'(c_fd), 32'd1);
        chk("A_front", 32'(bus.front_bank_out), 32'd1);
        chk("A_le", 32'(c_le), 32'd0);
        chk("A_fe", 32'(c_fe), 32'd0);
        chk("A_q", 32'(exp_q.size()), 32'd0);
        chk("A_ovf", 32'(bus.overflow_out), 32'd0);

        // Pixel in VBlank: dropped silently.
        px(1'b1);
        repeat (2) step();
        chk("vb_ovf", 32'(bus.overflow_out), 32'd0);

        // Frame B: full frame into bank 0.
        full_frame();
        chk("B_nwr", 32'(n_wr), 32'd23040);
        chk("B_first", 32'(first_a), 32'h0000);
        chk("B_last", 32'(last_a), 32'h59FF);
        chk("B_done", 32'(c_fd), 32'd1);
        chk("B_front", 32'(bus.front_bank_out), 32'd0);
        chk("B_le", 32'(c_le), 32'd0);
        chk("B_fe", 32'(c_fe), 32'd0);
        chk("B_q", 32'(exp_q.size()), 32'd0);

        // Frame C: short line, HBlank pixel, 161st pixel,
        // short lines, then 143rd line ends with coincident edges.
        frame_start();
        repeat (159) px(1'b0);
        hb(1'b1);
        chk("C_le0", 32'(c_le), 32'd1);
        chk("C_hb_ovf", 32'(bus.overflow_out), 32'd1);
        repeat (161) px(1'b0);
        hb(1'b0);
        chk("C_le1", 32'(c_le), 32'd1);
        for (int l = 2; l < 142; l++) begin
            repeat (8) px(1'b0);
            hb(1'b0);
        end
        repeat (159) px(1'b0);
        bus.hblank_in = 1'b1;
        bus.vblank_in = 1'b1;
        step();
        px(1'b0);
        repeat (3) step();
        bus.hblank_in = 1'b0;
        ln++;
        col = 0;
        bank = ~bank;
        chk("C_le", 32'(c_le), 32'd141);
        chk("C_fe", 32'(c_fe), 32'd1);
        chk("C_done", 32'(c_fd), 32'd1);
        chk("C_front", 32'(bus.front_bank_out), 32'd1);
        chk("C_ovf_held", 32'(bus.overflow_out), 32'd1);
        chk("C_q", 32'(exp_q.size()), 32'd0);

        // Mid-line asynchronous reset.
        frame_start();
        repeat (5) px(1'b0);
        bus.pixel_valid_in = 1'b1;
        #1;
        chk("pre_rst_wr", 32'(bus.wr_en_out), 32'd1);
        rst_n_in = 1'b0;
        #1;
        chk("ar_wr_en", 32'(bus.wr_en_out), 32'd0);
        chk("ar_front", 32'(bus.front_bank_out), 32'd0);
        chk("ar_ovf", 32'(bus.overflow_out), 32'd0);
        chk("ar_q", 32'(exp_q.size()), 32'd1);
        exp_q.delete();
        bus.vblank_in = 1'b1;
        repeat (3) step();
        rst_n_in = 1'b1;
        clr_cnt();
        repeat (10) step();
        bus.pixel_valid_in = 1'b0;
        chk("sync_nwr", 32'(n_wr), 32'd0);
        chk("sync_ovf", 32'(bus.overflow_out), 32'd0);

        // Next frame after the reset writes bank 1 from index 0.
        bank = 1'b1;
        frame_start();
        repeat (4) px(1'b0);
        repeat (2) step();
        chk("post_nwr", 32'(n_wr), 32'd4);
        chk("post_first", 32'(first_a), 32'h8000);
        chk("post_q", 32'(exp_q.size()), 32'd0);
        chk("post_front", 32'(bus.front_bank_out), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
